alu_issue_ctrl: RTL and testbench

//   Upstream command front-end for the 4-bit registered ALU. Buffers {op,a,b} commands

---
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Command front-end for the registered 4-bit ALU: queues {op,a,b} commands, issues them
// under a result-FIFO credit rule, tracks pipeline latency with tags, returns results in order.
module alu_issue_ctrl #(
    parameter int CMD_DEPTH = 4,
    parameter int ALU_LAT   = 2,
    parameter int RES_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [1:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_y,
    input  logic       alu_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_y,
    output logic       res_carry,
    output logic [1:0] res_op,
    output logic       busy
);
    localparam int CPW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CCW = $clog2(CMD_DEPTH + 1);
    localparam int RPW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int RCW = $clog2(RES_DEPTH + 1);
    localparam int IFW = $clog2(ALU_LAT + 2);
    localparam int SW  = $clog2(ALU_LAT + RES_DEPTH + 2) + 1;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] op;
    } tag_t;

    typedef struct packed {
        logic [1:0] op;
        logic       carry;
        logic [3:0] y;
    } res_t;

    cmd_t           cmd_mem_q [CMD_DEPTH];
    logic [CPW-1:0] cmd_wr_q, cmd_rd_q;
    logic [CCW-1:0] cmd_cnt_q, cmd_cnt_d;
    res_t           res_mem_q [RES_DEPTH];
    logic [RPW-1:0] res_wr_q, res_rd_q;
    logic [RCW-1:0] res_cnt_q, res_cnt_d;
    tag_t           tag_q [ALU_LAT+1];
    tag_t           tag_d;
    cmd_t           alu_q;
    res_t           res_head;

    logic           cmd_full, cmd_push, issue, capture, res_pop;
    logic [IFW-1:0] inflight;
    logic [SW-1:0]  credit_used;

    function automatic logic [RPW-1:0] res_ptr_inc(input logic [RPW-1:0] p);
        return (p == RPW'(RES_DEPTH - 1)) ? '0 : p + RPW'(1);
    endfunction

    assign cmd_full  = (cmd_cnt_q == CCW'(CMD_DEPTH));
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && !cmd_full;
    assign res_valid = (res_cnt_q != '0);
    assign res_pop   = res_valid && res_ready;
    assign capture   = tag_q[ALU_LAT].valid;

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so the loop below accumulates correctly and no latch can be inferred.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            inflight = inflight + IFW'(tag_q[i].valid);
        end
    end

    // A slot is reserved for every tag in the pipe, so a capture always finds room.
    assign credit_used = SW'(inflight) + SW'(res_cnt_q) - SW'(res_pop);
    assign issue       = (cmd_cnt_q != '0) && (credit_used < SW'(RES_DEPTH));

    always_comb begin
        tag_d     = '0;
        cmd_cnt_d = cmd_cnt_q;
        res_cnt_d = res_cnt_q;
        if (issue) begin
            tag_d.valid = 1'b1;
            tag_d.op    = cmd_mem_q[cmd_rd_q].op;
        end
        case ({cmd_push, issue})
            2'b10:   cmd_cnt_d = cmd_cnt_q + CCW'(1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - CCW'(1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
        case ({capture, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + RCW'(1);
            2'b01:   res_cnt_d = res_cnt_q - RCW'(1);
            default: res_cnt_d = res_cnt_q;
        endcase
    end

    // NOTE: storage arrays are not reset; occupancy counters define validity and the
    // result outputs are gated by res_valid, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
        if (capture)  res_mem_q[res_wr_q] <= '{op: tag_q[ALU_LAT].op, carry: alu_carry, y: alu_y};
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
            alu_q     <= '0;
            for (int i = 0; i <= ALU_LAT; i++) tag_q[i] <= '0;
        end else begin
            if (cmd_push) cmd_wr_q <= cmd_wr_q + CPW'(1);
            if (issue) begin
                cmd_rd_q <= cmd_rd_q + CPW'(1);
                alu_q    <= cmd_mem_q[cmd_rd_q];
            end
            cmd_cnt_q <= cmd_cnt_d;
            tag_q[0]  <= tag_d;
            for (int i = 1; i <= ALU_LAT; i++) tag_q[i] <= tag_q[i-1];
            if (capture) res_wr_q <= res_ptr_inc(res_wr_q);
            if (res_pop) res_rd_q <= res_ptr_inc(res_rd_q);
            res_cnt_q <= res_cnt_d;
        end
    end

    assign alu_op = alu_q.op;
    assign alu_a  = alu_q.a;
    assign alu_b  = alu_q.b;

    assign res_head  = res_mem_q[res_rd_q];
    assign res_y     = res_valid ? res_head.y     : '0;
    assign res_carry = res_valid ? res_head.carry : 1'b0;
    assign res_op    = res_valid ? res_head.op    : '0;

    assign busy = (cmd_cnt_q != '0) || (inflight != '0) || (res_cnt_q != '0);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural 2-cycle registered ALU,
// scoreboard of expected results pushed on command accept, popped on result handshake.
module tb_alu_issue_ctrl;
    localparam int RES_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_a = '0, cmd_b = '0;
    logic [1:0] alu_op;
    logic [3:0] alu_a, alu_b, alu_y;
    logic       alu_carry;
    logic       res_valid, res_ready = 1'b1;
    logic [3:0] res_y;
    logic       res_carry;
    logic [1:0] res_op;
    logic       busy;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] y;
        logic       c;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_carry(res_carry), .res_op(res_op),
        .busy(busy)
    );

    function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Registered ALU: samples operands at an edge, result valid two edges later; never reset.
    logic [4:0] s1_q = '0, s2_q = '0;
    always @(posedge clk) begin
        s1_q <= alu_f(alu_op, alu_a, alu_b);
        s2_q <= s1_q;
    end
    assign alu_y     = s2_q[3:0];
    assign alu_carry = s2_q[4];

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            exp_t e;
            pops++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got op=%0d y=%h c=%0d, expected no result", res_op, res_y, res_carry);
            end else begin
                e = sb_q.pop_front();
                if ({res_op, res_y, res_carry} !== {e.op, e.y, e.c}) begin
                    errors++;
                    $display("FAIL result_order: got op=%0d y=%h c=%0d, expected op=%0d y=%h c=%0d",
                             res_op, res_y, res_carry, e.op, e.y, e.c);
                end
            end
        end
        if (rst_n && int'(dut.res_cnt_q) > RES_DEPTH) begin
            errors++;
            $display("FAIL res_overflow: occupancy %0d, limit %0d", dut.res_cnt_q, RES_DEPTH);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one command; called just after a posedge, returns just after the accept edge.
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                            input int max_wait, output bit ok);
        logic [4:0] r;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                r = alu_f(op, a, b);
                sb_q.push_back('{op: op, y: r[3:0], c: r[4]});
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
    endtask

    // Returns at the negedge where res_valid is first seen; lat counts edges since the call.
    task automatic wait_res(input int max_wait, output int lat, output logic [3:0] y,
                            output logic c, output logic [1:0] op);
        lat = -1; y = '0; c = 1'b0; op = '0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = i; y = res_y; c = res_carry; op = res_op;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0d, expected 1", cmd_ready); end
        checks++;
        if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_valid_busy: got %b, expected 00", {res_valid, busy}); end
        checks++;
        if ({alu_op, alu_a, alu_b, res_y, res_carry, res_op} !== 17'd0) begin
            errors++;
            $display("FAIL reset_data: got alu=%h/%h/%h res=%h/%0d/%0d, expected all 0", alu_op, alu_a, alu_b, res_y, res_carry, res_op);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    task automatic test_latency;
        bit ok; int lat; logic [3:0] y; logic c; logic [1:0] op;
        res_ready = 1'b1;
        send_cmd(2'b00, 4'd9, 4'd8, 10, ok);
        wait_res(20, lat, y, c, op);
        checks++;
        if (!ok || lat != 4) begin errors++; $display("FAIL add_latency: got %0d edges (accepted=%0d), expected 4", lat, ok); end
        checks++;
        if ({op, y, c} !== {2'b00, 4'd1, 1'b1}) begin
            errors++; $display("FAIL add_9_8: got op=%0d y=%h c=%0d, expected op=0 y=1 c=1", op, y, c);
        end
        @(posedge clk) #1;
    endtask

    task automatic test_ops;
        logic [1:0] t_op [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
        logic [3:0] t_a  [4] = '{4'h3, 4'h7, 4'hC, 4'h5};
        logic [3:0] t_b  [4] = '{4'h5, 4'h2, 4'hA, 4'hA};
        logic [3:0] t_y  [4] = '{4'hE, 4'h5, 4'h8, 4'hF};
        logic       t_c  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        bit ok; int lat; logic [3:0] y; logic c; logic [1:0] op;
        for (int i = 0; i < 4; i++) begin
            send_cmd(t_op[i], t_a[i], t_b[i], 10, ok);
            wait_res(20, lat, y, c, op);
            checks++;
            if (!ok || {op, y, c} !== {t_op[i], t_y[i], t_c[i]}) begin
                errors++;
                $display("FAIL op_case%0d: got op=%0d y=%h c=%0d lat=%0d, expected op=%0d y=%h c=%0d",
                         i, op, y, c, lat, t_op[i], t_y[i], t_c[i]);
            end
            @(posedge clk) #1;
        end
    endtask

    task automatic test_back_to_back;
        int streak = 0;
        bit seen = 1'b0;
        int not_acc = 0;
        res_ready = 1'b1;
        fork
            begin
                bit ok;
                for (int i = 0; i < 8; i++) begin
                    send_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 10, ok);
                    if (!ok) not_acc++;
                end
            end
            begin
                for (int i = 0; i < 30 && !seen; i++) begin
                    @(negedge clk);
                    seen = res_valid;
                end
                if (seen) begin
                    streak = 1;
                    for (int i = 1; i < 8; i++) begin
                        @(negedge clk);
                        if (res_valid) streak++;
                    end
                end
            end
        join
        checks++;
        if (streak != 8 || not_acc != 0) begin
            errors++; $display("FAIL back_to_back: got %0d consecutive results (%0d rejected), expected 8", streak, not_acc);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %0d outstanding busy=%0d, expected 0 busy=0", sb_q.size(), busy);
        end
    endtask

    task automatic test_backpressure;
        bit ok; int accepted = 0; int pops0;
        res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_cmd(2'(i), 4'(i + 3), 4'(2 * i), 8, ok);
            if (!ok) break;
            accepted++;
        end
        @(negedge clk);
        checks++;
        if (accepted != 8) begin errors++; $display("FAIL stall_accepts: got %0d, expected 8", accepted); end
        checks++;
        if ({cmd_ready, res_valid, busy} !== 3'b011) begin
            errors++; $display("FAIL stall_state: got ready/valid/busy=%b, expected 011", {cmd_ready, res_valid, busy});
        end
        @(posedge clk) #1;
        // Offer the rejected command again in the same cycle the first result pops.
        pops0 = pops;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_push_ready: got %0d, expected 0", cmd_ready); end
        @(posedge clk) #1 cmd_valid = 1'b0;
        for (int i = 0; i < 40 && busy; i++) @(posedge clk);
        #1;
        checks++;
        if (pops - pops0 != 8 || sb_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_drain: got %0d results, %0d outstanding, busy=%0d, expected 8, 0, 0",
                               pops - pops0, sb_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid;
        bit ok; bit stray = 1'b0; int lat; logic [3:0] y; logic c; logic [1:0] op;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_cmd(2'b00, 4'(i), 4'd1, 8, ok);
        checks++;
        if ({res_valid, busy} !== 2'b11) begin errors++; $display("FAIL pre_reset_state: got %b, expected 11", {res_valid, busy}); end
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        checks++;
        if ({cmd_ready, res_valid, busy, alu_op, alu_a, alu_b, res_y, res_carry, res_op} !== {1'b1, 19'd0}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ready=%0d valid=%0d busy=%0d alu=%h/%h/%h res=%h/%0d/%0d, expected 1,0,0 and zeros",
                     cmd_ready, res_valid, busy, alu_op, alu_a, alu_b, res_y, res_carry, res_op);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid || busy) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL post_reset_idle: got activity after reset, expected none"); end
        @(posedge clk) #1;
        send_cmd(2'b11, 4'h3, 4'h4, 10, ok);
        wait_res(20, lat, y, c, op);
        checks++;
        if (!ok || lat != 4 || {op, y, c} !== {2'b11, 4'h7, 1'b0}) begin
            errors++; $display("FAIL post_reset_cmd: got op=%0d y=%h c=%0d lat=%0d, expected op=3 y=7 c=0 lat=4", op, y, c, lat);
        end
        @(posedge clk) #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL final_scoreboard: got %0d outstanding, expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
